scan_doubler: RTL and testbench



---
 rtl/scan_doubler.sv | 165 ++++++++++++++++
 tb/tb_scan_doubler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_doubler.sv
// scan_doubler: turns the 15 kHz ULA pixel stream into a 31 kHz VGA stream by
// writing each input line into one of two ping-pong line buffers while the other
// buffer is read out twice at the full clock rate.
// Optional build macro: SCANLINES_EN (darkens the second pass of each line).
module scan_doubler #(
    parameter int AW      = 9,
    parameter int HSYNC_W = 48
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic [1:0]    syncIn,
    input  logic [8:0]    rgbIn,
    output logic [1:0]    sync,
    output logic [8:0]    rgb,
    output logic [AW-1:0] lineLen
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] HSYNC_LIM = HSYNC_W[AW:0];

    logic [8:0]    mem [0:2*DEPTH-1];

    logic [AW-1:0] wrAddr;
    logic [AW-1:0] wrAddrNext;
    logic          wrBank;
    logic          prevHsync;
    logic          vsyncSampled;
    logic          synced;
    logic          valid;

    logic [AW:0]   rdAddr;
    logic [AW:0]   rdNext;
    logic [AW:0]   lastAddr;
    logic          pass;
    logic          done;
    logic [AW-1:0] passPos;

    logic          hsyncEdge;
    logic          active;
    logic          hsyncLow;

    logic [8:0]    ramQ;
    logic          blank1;
    logic          hsync1;
    logic          vsync1;
    logic [8:0]    shadedPix;
`ifdef SCANLINES_EN
    logic          pass1;
`endif

    // A line boundary is an hsync falling edge seen on two consecutive input samples.
    // The pixel sampled on the edge still belongs to the line that is ending, so the
    // measured length includes it (saturated write address after that final write).
    assign hsyncEdge  = ce && prevHsync && !syncIn[0];
    assign wrAddrNext = (&wrAddr) ? wrAddr : wrAddr + AW'(1);

    // Read side runs only once a full line has been measured in the read bank.
    // Within pass 1 the buffer address wraps back by lineLen; the AW-bit difference
    // is exact because the position is always below lineLen.
    assign active   = valid && (lineLen != '0);
    assign lastAddr = {lineLen, 1'b0} - (AW+1)'(1);
    assign rdNext   = rdAddr + (AW+1)'(1);
    assign passPos  = pass ? (rdAddr[AW-1:0] - lineLen) : rdAddr[AW-1:0];
    assign hsyncLow = active && !done && ({1'b0, passPos} < HSYNC_LIM);

    // Line buffer write port: the bank being filled at the input pixel rate.
    always_ff @(posedge clock) begin
        if (ce) begin
            mem[{wrBank, wrAddr}] <= rgbIn;
        end
    end

    // Line buffer read port: always from the bank that is not being written.
    always_ff @(posedge clock) begin
        ramQ <= mem[{~wrBank, passPos}];
    end

    // Input side: sample sync, advance the write address, and swap banks on each line edge.
    // The first edge after reset only synchronises; the line before it is partial.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrAddr       <= '0;
            wrBank       <= 1'b0;
            lineLen      <= '0;
            valid        <= 1'b0;
            synced       <= 1'b0;
            prevHsync    <= 1'b1;
            vsyncSampled <= 1'b1;
        end else if (ce) begin
            prevHsync    <= syncIn[0];
            vsyncSampled <= syncIn[1];
            if (hsyncEdge) begin
                lineLen <= wrAddrNext;
                wrAddr  <= '0;
                wrBank  <= ~wrBank;
                valid   <= synced && (wrAddr != '0);
                synced  <= 1'b1;
            end else begin
                wrAddr  <= wrAddrNext;
            end
        end
    end

    // Output side: step through both passes once per input line, then hold until the next edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdAddr <= '0;
            pass   <= 1'b0;
            done   <= 1'b0;
        end else if (hsyncEdge) begin
            rdAddr <= '0;
            pass   <= 1'b0;
            done   <= 1'b0;
        end else if (active && !done) begin
            if (rdAddr == lastAddr) begin
                done <= 1'b1;
            end else begin
                rdAddr <= rdNext;
                pass   <= (rdNext >= {1'b0, lineLen});
            end
        end
    end

    // First pipeline stage: carry sync and blanking alongside the registered RAM read.
    always_ff @(posedge clock) begin
        if (reset) begin
            blank1 <= 1'b1;
            hsync1 <= 1'b1;
            vsync1 <= 1'b1;
`ifdef SCANLINES_EN
            pass1  <= 1'b0;
`endif
        end else begin
            blank1 <= !active || done || hsyncLow;
            hsync1 <= !hsyncLow;
            vsync1 <= vsyncSampled;
`ifdef SCANLINES_EN
            pass1  <= pass;
`endif
        end
    end

    // Pixel shading: the repeated pass is halved per component when scanlines are built in.
    always_comb begin
        shadedPix = ramQ;
`ifdef SCANLINES_EN
        if (pass1) begin
            shadedPix = {1'b0, ramQ[8:7], 1'b0, ramQ[5:4], 1'b0, ramQ[2:1]};
        end
`endif
    end

    // Output register: everything leaves together, two clocks after the read address.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= 2'b11;
            rgb  <= '0;
        end else begin
            sync <= {vsync1, hsync1};
            rgb  <= blank1 ? 9'd0 : shadedPix;
        end
    end

endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: directed checks of the scan doubler with hand-computed expectations.
module tb_scan_doubler;

    localparam int AW = 9;
`ifdef SCANLINES_EN
    localparam logic [8:0] PASS1_WHITE = 9'h0DB;
`else
    localparam logic [8:0] PASS1_WHITE = 9'h1FF;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b0;
    logic [1:0]    syncIn = 2'b11;
    logic [8:0]    rgbIn = '0;
    logic [1:0]    sync;
    logic [8:0]    rgb;
    logic [AW-1:0] lineLen;

    int checks = 0;
    int passed = 0;

    logic [8:0]    capRgb  [0:1199];
    logic [1:0]    capSync [0:1199];
    logic [AW-1:0] capLen  [0:1199];
    int            capN;

    scan_doubler #(.AW(AW), .HSYNC_W(48)) dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .syncIn  (syncIn),
        .rgbIn   (rgbIn),
        .sync    (sync),
        .rgb     (rgb),
        .lineLen (lineLen)
    );

    // Free-running output pixel clock.
    always #5 clock = ~clock;

    // One clock of stimulus; outputs are captured 1 time unit after the edge.
    task automatic clockOnce(input bit ceV, input bit hs, input bit vs,
                             input logic [8:0] pix, input bit rst);
        ce     = ceV;
        syncIn = {vs, hs};
        rgbIn  = pix;
        reset  = rst;
        @(posedge clock);
        #1;
        if (capN < 1200) begin
            capRgb[capN]  = rgb;
            capSync[capN] = sync;
            capLen[capN]  = lineLen;
        end
        capN++;
    endtask

    // One input line of n samples; hsync is low on the last sample and the first 15,
    // so the falling edge lands on the final pixel of the line.
    task automatic driveLine(input int n, input bit vsLow, input int resetAt,
                             input bit useConst, input logic [8:0] constPix);
        capN = 0;
        for (int p = 0; p < n; p++) begin
            logic [8:0] pix;
            bit hs;
            pix = useConst ? constPix : 9'(p);
            hs  = !((p == n - 1) || (p < 15));
            clockOnce(1'b1, hs, !vsLow, pix, p == resetAt);
            clockOnce(1'b0, hs, !vsLow, pix, 1'b0);
        end
    endtask

    task automatic test_reset();
        capN = 0;
        for (int i = 0; i < 44; i++) begin
            clockOnce(i % 2 == 0, 1'b1, 1'b1, 9'(i), i < 4);
            checks++;
            if (sync !== 2'b11) $display("[TB] FAIL reset_sync clk=%0d got=%b exp=11", i, sync);
            else passed++;
            checks++;
            if (rgb !== 9'd0) $display("[TB] FAIL reset_rgb clk=%0d got=%h exp=000", i, rgb);
            else passed++;
            checks++;
            if (lineLen !== '0) $display("[TB] FAIL reset_len clk=%0d got=%0d exp=0", i, lineLen);
            else passed++;
        end
    endtask

    task automatic test_line224();
        int pos;
        logic [8:0] expRgb;
        logic [1:0] expSync;
        capN = 0;
        clockOnce(1'b1, 1'b0, 1'b1, 9'd0, 1'b0);
        clockOnce(1'b0, 1'b0, 1'b1, 9'd0, 1'b0);
        driveLine(224, 1'b0, -1, 1'b0, 9'd0);
        checks++;
        if (lineLen !== 9'd224) $display("[TB] FAIL len224 got=%0d exp=224", lineLen);
        else passed++;
        driveLine(224, 1'b0, -1, 1'b0, 9'd0);
        for (int k = 0; k < 448; k++) begin
            pos     = k % 224;
            expRgb  = (pos < 48) ? 9'd0 : 9'(pos);
            expSync = {1'b1, pos >= 48};
            checks++;
            if (capRgb[k] !== expRgb || capSync[k] !== expSync)
                $display("[TB] FAIL line224 k=%0d got rgb=%h sync=%b exp rgb=%h sync=%b",
                         k, capRgb[k], capSync[k], expRgb, expSync);
            else passed++;
        end
    endtask

    task automatic test_long_line();
        int pos;
        logic [8:0] expRgb;
        logic [1:0] expSync;
        logic [8:0] lastEntry;
        driveLine(600, 1'b0, -1, 1'b0, 9'd0);
        checks++;
        if (lineLen !== 9'd511) $display("[TB] FAIL len600 got=%0d exp=511", lineLen);
        else passed++;
        lastEntry = dut.mem[{~dut.wrBank, 9'd511}];
        checks++;
        if (lastEntry !== 9'h057) $display("[TB] FAIL entry511 got=%h exp=057", lastEntry);
        else passed++;
        driveLine(600, 1'b0, -1, 1'b0, 9'd0);
        for (int k = 0; k < 1200; k++) begin
            if (k < 1022) begin
                pos     = (k < 511) ? k : k - 511;
                expRgb  = (pos < 48) ? 9'd0 : 9'(pos);
                expSync = {1'b1, pos >= 48};
            end else begin
                expRgb  = 9'd0;
                expSync = 2'b11;
            end
            checks++;
            if (capRgb[k] !== expRgb || capSync[k] !== expSync)
                $display("[TB] FAIL line600 k=%0d got rgb=%h sync=%b exp rgb=%h sync=%b",
                         k, capRgb[k], capSync[k], expRgb, expSync);
            else passed++;
        end
    endtask

    task automatic test_vsync();
        int lowTotal = 0;
        int lowCount;
        int edgeAt;
        driveLine(224, 1'b1, -1, 1'b0, 9'd0);
        edgeAt = -1;
        lowCount = 0;
        for (int k = 0; k < 448; k++) begin
            if (capSync[k][1] === 1'b0) begin
                lowCount++;
                if (edgeAt < 0) edgeAt = k;
            end
        end
        lowTotal += lowCount;
        checks++;
        if (edgeAt !== 2) $display("[TB] FAIL vsync_onset got=%0d exp=2", edgeAt);
        else passed++;
        for (int l = 0; l < 2; l++) begin
            driveLine(224, 1'b1, -1, 1'b0, 9'd0);
            lowCount = 0;
            for (int k = 0; k < 448; k++) if (capSync[k][1] === 1'b0) lowCount++;
            lowTotal += lowCount;
            checks++;
            if (lowCount !== 448) $display("[TB] FAIL vsync_mid line=%0d got=%0d exp=448", l, lowCount);
            else passed++;
        end
        driveLine(224, 1'b0, -1, 1'b0, 9'd0);
        edgeAt = -1;
        lowCount = 0;
        for (int k = 0; k < 448; k++) begin
            if (capSync[k][1] === 1'b0) lowCount++;
            else if (edgeAt < 0) edgeAt = k;
        end
        lowTotal += lowCount;
        checks++;
        if (edgeAt !== 2) $display("[TB] FAIL vsync_release got=%0d exp=2", edgeAt);
        else passed++;
        checks++;
        if (lowTotal !== 1344) $display("[TB] FAIL vsync_span got=%0d exp=1344", lowTotal);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int pos;
        logic [8:0] expRgb;
        logic [1:0] expSync;
        driveLine(224, 1'b0, 150, 1'b0, 9'd0);
        checks++;
        if (capRgb[299] !== 9'd75) $display("[TB] FAIL pre_reset_rgb got=%h exp=04b", capRgb[299]);
        else passed++;
        checks++;
        if (capLen[300] !== '0) $display("[TB] FAIL reset_mid_len got=%0d exp=0", capLen[300]);
        else passed++;
        for (int k = 300; k < 448; k++) begin
            checks++;
            if (capRgb[k] !== 9'd0 || capSync[k] !== 2'b11)
                $display("[TB] FAIL reset_mid k=%0d got rgb=%h sync=%b exp rgb=000 sync=11",
                         k, capRgb[k], capSync[k]);
            else passed++;
        end
        driveLine(224, 1'b0, -1, 1'b0, 9'd0);
        for (int k = 0; k < 448; k++) begin
            checks++;
            if (capRgb[k] !== 9'd0 || capSync[k] !== 2'b11)
                $display("[TB] FAIL resync_blank k=%0d got rgb=%h sync=%b exp rgb=000 sync=11",
                         k, capRgb[k], capSync[k]);
            else passed++;
        end
        driveLine(224, 1'b0, -1, 1'b0, 9'd0);
        for (int k = 0; k < 448; k++) begin
            pos     = k % 224;
            expRgb  = (pos < 48) ? 9'd0 : 9'(pos);
            expSync = {1'b1, pos >= 48};
            checks++;
            if (capRgb[k] !== expRgb || capSync[k] !== expSync)
                $display("[TB] FAIL resumed k=%0d got rgb=%h sync=%b exp rgb=%h sync=%b",
                         k, capRgb[k], capSync[k], expRgb, expSync);
            else passed++;
        end
    endtask

    task automatic test_scanlines();
        int pos;
        logic [8:0] expRgb;
        driveLine(224, 1'b0, -1, 1'b1, 9'h1FF);
        driveLine(224, 1'b0, -1, 1'b1, 9'h1FF);
        for (int k = 0; k < 448; k++) begin
            pos = k % 224;
            if (pos < 48)      expRgb = 9'd0;
            else if (k < 224)  expRgb = 9'h1FF;
            else               expRgb = PASS1_WHITE;
            checks++;
            if (capRgb[k] !== expRgb)
                $display("[TB] FAIL scanlines k=%0d got=%h exp=%h", k, capRgb[k], expRgb);
            else passed++;
        end
    endtask

    // Scenario sequence; each test continues from the stream state the previous one left.
    initial begin
        test_reset();
        test_line224();
        test_long_line();
        test_vsync();
        test_reset_mid();
        test_scanlines();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
